// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M execute-stage sequencer.
//   funct3_e - RV32M funct3 encodings (MUL .. REMU)
//   state_e  - sequencer FSM states
//   XLEN, CNT_W, INT_MIN, ALL_ONES - datapath width and special operand values
//   abs_val, cond_negate - sign-magnitude helpers used by the divide path
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Magnitude of x when treated as signed; INT_MIN maps to 2^31, which is the
  // correct unsigned magnitude for the divider.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x,
                                              input logic            is_signed);
    logic [XLEN-1:0] r;
    if (is_signed && x[XLEN-1]) begin
      r = ~x + 32'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Two's-complement negate when en is set.
  function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] x,
                                                  input logic            en);
    logic [XLEN-1:0] r;
    if (en) begin
      r = ~x + 32'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage request/response bundle for the M-extension sequencer.
//   valid_i, funct3_i, op_a_i, op_b_i, flush_i - request side, driven by EX
//   stall_o, done_o, result_o                   - response side, driven by the sequencer
// master = pipeline side, slave = sequencer side.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            valid_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, funct3_i, op_a_i, op_b_i, flush_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  valid_i, funct3_i, op_a_i, op_b_i, flush_i,
    output stall_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem, quo, divisor  in  - current partial remainder, dividend/quotient shift
//                            register, divisor magnitude
//   rem_next, quo_next out - state after shifting {rem,quo} left and subtracting
// Invariant: rem < divisor on entry, so the shifted remainder fits in XLEN+1 bits.
module div_step
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] trial_s;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shifted_s = {rem, quo[XLEN-1]};
    trial_s   = shifted_s - {1'b0, divisor};
    if (trial_s[XLEN] == 1'b0) begin
      rem_next = trial_s[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted_s[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M execute unit that stalls the pipeline.
//   clk  in      - clock
//   rst  in      - synchronous active-high reset
//   bus  slave   - valid_i/funct3_i/op_a_i/op_b_i/flush_i requests,
//                  stall_o/done_o/result_o responses (see muldiv_if)
// Multiply completes two cycles after accept, a normal divide 33 cycles after
// accept (32 restoring steps), divide-by-zero and signed overflow one cycle
// after accept. done_o is a one-cycle pulse; result_o holds between pulses.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  state_e           state_r;
  logic [2:0]       funct3_r;
  logic [XLEN-1:0]  op_a_r;
  logic [XLEN-1:0]  op_b_r;
  logic [XLEN-1:0]  quo_r;
  logic [XLEN-1:0]  rem_r;
  logic [XLEN-1:0]  divisor_r;
  logic [XLEN-1:0]  result_r;
  logic [CNT_W-1:0] counter_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             done_r;

  logic             div_signed_s;
  logic             div_zero_s;
  logic             div_ovf_s;
  logic             mul_sa_s;
  logic             mul_sb_s;
  logic [2*XLEN-1:0] mul_a_s;
  logic [2*XLEN-1:0] mul_b_s;
  logic [2*XLEN-1:0] mul_prod_s;
  logic [XLEN-1:0]  mul_res_s;
  logic [XLEN-1:0]  rem_next_s;
  logic [XLEN-1:0]  quo_next_s;
  logic [XLEN-1:0]  div_res_s;

  // Even funct3[0] selects the signed divide/remainder variants.
  assign div_signed_s = ~bus.funct3_i[0];
  assign div_zero_s   = (bus.op_b_i == 32'd0);
  assign div_ovf_s    = div_signed_s && (bus.op_a_i == INT_MIN) && (bus.op_b_i == ALL_ONES);

  // The accept cycle is stalled combinationally so IF/ID/EX hold immediately.
  assign bus.stall_o  = ((state_r == S_IDLE) && bus.valid_i && !bus.flush_i) ||
                        (state_r == S_MUL) || (state_r == S_DIV);
  assign bus.done_o   = done_r;
  assign bus.result_o = result_r;

  div_step u_div_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (rem_next_s),
    .quo_next (quo_next_s)
  );

  // Multiply: sign-extend both operands to 64 bits; the low 64 bits of the
  // product are then correct for every signed/unsigned combination.
  always_comb begin
    mul_sa_s = 1'b0;
    mul_sb_s = 1'b0;
    case (funct3_r)
      F_MUL, F_MULH: begin
        mul_sa_s = 1'b1;
        mul_sb_s = 1'b1;
      end
      F_MULHSU: begin
        mul_sa_s = 1'b1;
        mul_sb_s = 1'b0;
      end
      F_MULHU: begin
        mul_sa_s = 1'b0;
        mul_sb_s = 1'b0;
      end
      default: begin
        mul_sa_s = 1'b0;
        mul_sb_s = 1'b0;
      end
    endcase
    mul_a_s    = {{XLEN{mul_sa_s & op_a_r[XLEN-1]}}, op_a_r};
    mul_b_s    = {{XLEN{mul_sb_s & op_b_r[XLEN-1]}}, op_b_r};
    mul_prod_s = mul_a_s * mul_b_s;
    if (funct3_r == F_MUL) begin
      mul_res_s = mul_prod_s[XLEN-1:0];
    end else begin
      mul_res_s = mul_prod_s[2*XLEN-1:XLEN];
    end
  end

  // Divide result from the final step: funct3[1] selects remainder over quotient.
  always_comb begin
    if (funct3_r[1]) begin
      div_res_s = cond_negate(rem_next_s, neg_r_r);
    end else begin
      div_res_s = cond_negate(quo_next_s, neg_q_r);
    end
  end

  // Sequencer FSM with registered done/result; flush outranks everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      funct3_r  <= 3'b000;
      op_a_r    <= 32'd0;
      op_b_r    <= 32'd0;
      quo_r     <= 32'd0;
      rem_r     <= 32'd0;
      divisor_r <= 32'd0;
      result_r  <= 32'd0;
      counter_r <= 5'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      done_r    <= 1'b0;
    end else if (bus.flush_i) begin
      state_r <= S_IDLE;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.valid_i) begin
            funct3_r <= bus.funct3_i;
            op_a_r   <= bus.op_a_i;
            op_b_r   <= bus.op_b_i;
            if (!bus.funct3_i[2]) begin
              state_r <= S_MUL;
            end else if (div_zero_s) begin
              result_r <= bus.funct3_i[1] ? bus.op_a_i : ALL_ONES;
              done_r   <= 1'b1;
              state_r  <= S_DONE;
            end else if (div_ovf_s) begin
              result_r <= bus.funct3_i[1] ? 32'd0 : INT_MIN;
              done_r   <= 1'b1;
              state_r  <= S_DONE;
            end else begin
              quo_r     <= abs_val(bus.op_a_i, div_signed_s);
              divisor_r <= abs_val(bus.op_b_i, div_signed_s);
              rem_r     <= 32'd0;
              counter_r <= 5'd0;
              neg_q_r   <= div_signed_s & (bus.op_a_i[XLEN-1] ^ bus.op_b_i[XLEN-1]);
              neg_r_r   <= div_signed_s & bus.op_a_i[XLEN-1];
              state_r   <= S_DIV;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_MUL: begin
          result_r <= mul_res_s;
          done_r   <= 1'b1;
          state_r  <= S_DONE;
        end
        S_DIV: begin
          rem_r     <= rem_next_s;
          quo_r     <= quo_next_s;
          counter_r <= counter_r + 5'd1;
          if (counter_r == {CNT_W{1'b1}}) begin
            result_r <= div_res_s;
            done_r   <= 1'b1;
            state_r  <= S_DONE;
          end else begin
            state_r <= S_DIV;
          end
        end
        S_DONE: begin
          // valid_i may still be high here; it is not re-accepted until IDLE.
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
